fp_execute_stage2: RTL
======================

# fp_execute_stage2

Second stage of the floating point pipeline, directly downstream of fp_execute_stage1 and upstream of fp_execute_stage3. For float add, subtract, compare, itof and ftoi, it right-aligns the smaller-exponent significand and produces guard, round and sticky bits. For float and integer multiply, it forms the full 64-bit product. All per-lane control, and the instruction, mask, thread and subcycle, pass through one register stage, with rollback squash on the valid bit.

## Interface
- No module parameters.
- Lane count is NUM_VECTOR_LANES from the defines package (16).
- Widths below are per lane unless marked scalar.

Ports:
- clk  in  1  pipeline clock
- reset  in  1  synchronous, active-high
- wb_rollback_en  in  1  writeback rollback request
- wb_rollback_thread_idx  in  local_thread_idx_t  thread being rolled back
- fx1_instruction_valid, fx1_instruction, fx1_mask_value, fx1_thread_idx, fx1_subcycle  in  scalar types  stage-1 control
- fx1_result_inf, fx1_result_nan, fx1_equal, fx1_logical_subtract, fx1_add_result_sign, fx1_mul_underflow, fx1_mul_sign  in  1  stage-1 flags
- fx1_ftoi_lshift, fx1_se_align_shift  in  6  shift counts
- fx1_add_exponent, fx1_mul_exponent  in  8  exponents
- fx1_significand_le, fx1_significand_se, fx1_multiplicand, fx1_multiplier  in  32  operands
- fx2_instruction_valid, fx2_instruction, fx2_mask_value, fx2_thread_idx, fx2_subcycle  out  scalar types  registered control
- fx2_result_inf, fx2_result_nan, fx2_equal, fx2_logical_subtract, fx2_add_result_sign, fx2_mul_underflow, fx2_mul_sign  out  1  registered pass-through
- fx2_ftoi_lshift  out  6  pass-through
- fx2_add_exponent, fx2_mul_exponent  out  8  pass-through
- fx2_significand_le  out  32  pass-through
- fx2_significand_se  out  32  aligned smaller-exponent significand
- fx2_guard, fx2_round, fx2_sticky  out  1  bits shifted out of the aligned significand
- fx2_significand_product  out  64  full multiplier result

## Operation
**Alignment.** Let se = fx1_significand_se and s = fx1_se_align_shift, with s in 0..63.
- fx2_significand_se = se >> s. The result is 0 for s >= 32.
- fx2_guard = se[s-1] when 1 <= s <= 32, otherwise 0.
- fx2_round = se[s-2] when 2 <= s <= 33, otherwise 0.
- fx2_sticky = OR of se[min(s-3,31):0] when s >= 3, otherwise 0.
- These rules apply to every alu_op. itof arrives with s = 0, so all three rounding bits are 0.

**Multiply.**
- If fx1_instruction.alu_op == OP_MULH_I, fx2_significand_product = signed(multiplicand) * signed(multiplier), as a 64-bit two's complement value.
- For every other op (OP_MULL_I, OP_MULH_U, OP_MUL_F, non-multiply), the product is the unsigned 64-bit product.
- For OP_MUL_F the operands are 24-bit significands, so bits [63:48] are 0.

**Pass-through.** All other fx1_* per-lane and control fields are registered unchanged into the matching fx2_* output.

**Valid.**
- fx2_instruction_valid <= fx1_instruction_valid && !(wb_rollback_en && wb_rollback_thread_idx == fx1_thread_idx).
- A rollback for a different thread does not affect the stage.
- Datapath registers load every cycle regardless of valid. Downstream qualifies them by fx2_instruction_valid.

**Reset.** Synchronous, active-high. In a cycle with reset high, every output register, including all datapath outputs, loads 0 at the clock edge. Reset overrides a simultaneous valid input or rollback.

## Timing
- Latency is exactly 1 cycle for every output.
- Throughput is one instruction per cycle per lane.
- No stall, backpressure, or internal state beyond the output registers.
- Rollback is evaluated against the instruction present at fx1 in that cycle; it squashes only that instruction.
- The multiply and shift complete combinationally before the stage-2 edge. If timing fails, the multiplier may become a partial-product tree, provided the boundary latency stays at 1.
- Reset asserted mid-stream: the next edge yields all zeros. The first valid output appears one cycle after the first valid fx1 input following reset deassertion.

## Test plan
- **Align, shift 3.** se=0x0080_0007, s=3, fx1 valid → next cycle fx2_significand_se=0x0010_0000, guard=1, round=1, sticky=1, valid=1.
- **Full shift and large count.**
  - se=0x8000_0000, s=32 → se_out=0, guard=1, round=0, sticky=0.
  - se=0x8000_0000, s=33 → se_out=0, guard=0, round=1, sticky=0.
  - se=1, s=40 → se_out=0, guard=0, round=0, sticky=1.
- **Multiply.**
  - OP_MULH_I, 0xFFFF_FFFF × 0x0000_0002 → product 0xFFFF_FFFF_FFFF_FFFE.
  - Same operands with OP_MULH_U → product 0x0000_0001_FFFF_FFFE.
  - OP_MUL_F, 0x00C0_0000 × 0x00C0_0000 → product 0x0000_9000_0000_0000.
- **Rollback.**
  - fx1 valid with thread 2 and wb_rollback_en=1 for thread 2 → fx2_instruction_valid=0 next cycle.
  - Same input with rollback for thread 1 → valid=1, data intact.
- **Reset.** Stream 5 valid instructions, then assert reset for 1 cycle alongside a valid input → all fx2 outputs 0 after that edge. Outputs resume exactly 1 cycle after valid inputs restart.
- **Back-to-back pass-through.** Random per-lane fx1 flags, exponents and ftoi_lshift every cycle for 1000 cycles → each fx2 field equals its fx1 value delayed by 1 cycle.

Source files
------------

// File: rtl/fp_execute_stage2.sv
// fp_execute_stage2_pkg: the lane count, thread/mask/subcycle types, the
// decoded-instruction layout and the ALU opcodes that this stage needs.
//
// fp_execute_stage2: second floating point pipeline stage.
//   - Right-aligns the smaller-exponent significand by fx1_se_align_shift.
//     It produces the guard, round and sticky bits that fall off the right
//     end of the aligned value.
//   - Forms the full 64-bit product of multiplicand and multiplier. The
//     product is signed for OP_MULH_I and unsigned for every other op.
//   - Registers every other stage-1 field unchanged.
//   - The valid bit is squashed by a writeback rollback on the same thread.
//
// Ports:
//   clk, reset                          clock; synchronous active-high reset
//   wb_rollback_en/_thread_idx          rollback request from writeback
//   fx1_* (scalar)                      stage-1 valid, instruction, mask,
//                                       thread, subcycle
//   fx1_* (per lane)                    stage-1 flags, shifts, exponents,
//                                       operands
//   fx2_* (scalar)                      registered control
//   fx2_* (per lane)                    registered pass-through fields plus
//                                       significand_se, guard, round, sticky
//                                       and significand_product
// Latency is one cycle on every output. The only state is the output
// register bank.

package fp_execute_stage2_pkg;
  localparam int NUM_VECTOR_LANES = 16;

  typedef logic [1:0]                  local_thread_idx_t;
  typedef logic [NUM_VECTOR_LANES-1:0] vector_mask_t;
  typedef logic [3:0]                  subcycle_t;
  typedef logic [5:0]                  alu_op_t;

  localparam alu_op_t OP_MULL_I = 6'h07;
  localparam alu_op_t OP_MULH_U = 6'h08;
  localparam alu_op_t OP_MULH_I = 6'h1f;
  localparam alu_op_t OP_ADD_F  = 6'h20;
  localparam alu_op_t OP_MUL_F  = 6'h22;

  typedef struct packed {
    logic        has_dest;
    logic        dest_is_vector;
    logic [4:0]  dest_reg;
    alu_op_t     alu_op;
    logic [31:0] pc;
  } decoded_instruction_t;
endpackage

module fp_execute_stage2
  import fp_execute_stage2_pkg::*;
(
  input  logic                 clk,
  input  logic                 reset,

  input  logic                 wb_rollback_en,
  input  local_thread_idx_t    wb_rollback_thread_idx,

  input  logic                 fx1_instruction_valid,
  input  decoded_instruction_t fx1_instruction,
  input  vector_mask_t         fx1_mask_value,
  input  local_thread_idx_t    fx1_thread_idx,
  input  subcycle_t            fx1_subcycle,
  input  logic                 fx1_result_inf       [NUM_VECTOR_LANES],
  input  logic                 fx1_result_nan       [NUM_VECTOR_LANES],
  input  logic                 fx1_equal            [NUM_VECTOR_LANES],
  input  logic                 fx1_logical_subtract [NUM_VECTOR_LANES],
  input  logic                 fx1_add_result_sign  [NUM_VECTOR_LANES],
  input  logic                 fx1_mul_underflow    [NUM_VECTOR_LANES],
  input  logic                 fx1_mul_sign         [NUM_VECTOR_LANES],
  input  logic [5:0]           fx1_ftoi_lshift      [NUM_VECTOR_LANES],
  input  logic [5:0]           fx1_se_align_shift   [NUM_VECTOR_LANES],
  input  logic [7:0]           fx1_add_exponent     [NUM_VECTOR_LANES],
  input  logic [7:0]           fx1_mul_exponent     [NUM_VECTOR_LANES],
  input  logic [31:0]          fx1_significand_le   [NUM_VECTOR_LANES],
  input  logic [31:0]          fx1_significand_se   [NUM_VECTOR_LANES],
  input  logic [31:0]          fx1_multiplicand     [NUM_VECTOR_LANES],
  input  logic [31:0]          fx1_multiplier       [NUM_VECTOR_LANES],

  output logic                 fx2_instruction_valid,
  output decoded_instruction_t fx2_instruction,
  output vector_mask_t         fx2_mask_value,
  output local_thread_idx_t    fx2_thread_idx,
  output subcycle_t            fx2_subcycle,
  output logic                 fx2_result_inf          [NUM_VECTOR_LANES],
  output logic                 fx2_result_nan          [NUM_VECTOR_LANES],
  output logic                 fx2_equal               [NUM_VECTOR_LANES],
  output logic                 fx2_logical_subtract    [NUM_VECTOR_LANES],
  output logic                 fx2_add_result_sign     [NUM_VECTOR_LANES],
  output logic                 fx2_mul_underflow       [NUM_VECTOR_LANES],
  output logic                 fx2_mul_sign            [NUM_VECTOR_LANES],
  output logic [5:0]           fx2_ftoi_lshift         [NUM_VECTOR_LANES],
  output logic [7:0]           fx2_add_exponent        [NUM_VECTOR_LANES],
  output logic [7:0]           fx2_mul_exponent        [NUM_VECTOR_LANES],
  output logic [31:0]          fx2_significand_le      [NUM_VECTOR_LANES],
  output logic [31:0]          fx2_significand_se      [NUM_VECTOR_LANES],
  output logic                 fx2_guard               [NUM_VECTOR_LANES],
  output logic                 fx2_round               [NUM_VECTOR_LANES],
  output logic                 fx2_sticky              [NUM_VECTOR_LANES],
  output logic [63:0]          fx2_significand_product [NUM_VECTOR_LANES]
);

  // Combinational intermediates
  logic        is_mulh_i;
  logic [33:0] align_ext   [NUM_VECTOR_LANES];
  logic [31:0] sticky_mask [NUM_VECTOR_LANES];
  logic [63:0] mul_a       [NUM_VECTOR_LANES];
  logic [63:0] mul_b       [NUM_VECTOR_LANES];

  // Next-state values
  logic                 instruction_valid_d;
  decoded_instruction_t instruction_d;
  vector_mask_t         mask_value_d;
  local_thread_idx_t    thread_idx_d;
  subcycle_t            subcycle_d;
  logic                 result_inf_d          [NUM_VECTOR_LANES];
  logic                 result_nan_d          [NUM_VECTOR_LANES];
  logic                 equal_d               [NUM_VECTOR_LANES];
  logic                 logical_subtract_d    [NUM_VECTOR_LANES];
  logic                 add_result_sign_d     [NUM_VECTOR_LANES];
  logic                 mul_underflow_d       [NUM_VECTOR_LANES];
  logic                 mul_sign_d            [NUM_VECTOR_LANES];
  logic [5:0]           ftoi_lshift_d         [NUM_VECTOR_LANES];
  logic [7:0]           add_exponent_d        [NUM_VECTOR_LANES];
  logic [7:0]           mul_exponent_d        [NUM_VECTOR_LANES];
  logic [31:0]          significand_le_d      [NUM_VECTOR_LANES];
  logic [31:0]          significand_se_d      [NUM_VECTOR_LANES];
  logic                 guard_d               [NUM_VECTOR_LANES];
  logic                 round_d               [NUM_VECTOR_LANES];
  logic                 sticky_d              [NUM_VECTOR_LANES];
  logic [63:0]          significand_product_d [NUM_VECTOR_LANES];

  // Output registers
  logic                 instruction_valid_q;
  decoded_instruction_t instruction_q;
  vector_mask_t         mask_value_q;
  local_thread_idx_t    thread_idx_q;
  subcycle_t            subcycle_q;
  logic                 result_inf_q          [NUM_VECTOR_LANES];
  logic                 result_nan_q          [NUM_VECTOR_LANES];
  logic                 equal_q               [NUM_VECTOR_LANES];
  logic                 logical_subtract_q    [NUM_VECTOR_LANES];
  logic                 add_result_sign_q     [NUM_VECTOR_LANES];
  logic                 mul_underflow_q       [NUM_VECTOR_LANES];
  logic                 mul_sign_q            [NUM_VECTOR_LANES];
  logic [5:0]           ftoi_lshift_q         [NUM_VECTOR_LANES];
  logic [7:0]           add_exponent_q        [NUM_VECTOR_LANES];
  logic [7:0]           mul_exponent_q        [NUM_VECTOR_LANES];
  logic [31:0]          significand_le_q      [NUM_VECTOR_LANES];
  logic [31:0]          significand_se_q      [NUM_VECTOR_LANES];
  logic                 guard_q               [NUM_VECTOR_LANES];
  logic                 round_q               [NUM_VECTOR_LANES];
  logic                 sticky_q              [NUM_VECTOR_LANES];
  logic [63:0]          significand_product_q [NUM_VECTOR_LANES];

  assign is_mulh_i = (fx1_instruction.alu_op == OP_MULH_I);

  always_comb begin
    for (int lane = 0; lane < NUM_VECTOR_LANES; lane++) begin
      // Two extra low bits catch guard (bit 1) and round (bit 0). The
      // shifter zero-fills for counts past the width, which gives the
      // right result for every count up to 63.
      align_ext[lane] = {fx1_significand_se[lane], 2'b00} >> fx1_se_align_shift[lane];

      // Sticky covers se[s-3:0]. The shifter above cannot produce it,
      // because bits shifted past the extension are lost.
      if (fx1_se_align_shift[lane] < 6'd3)
        sticky_mask[lane] = '0;
      else if (fx1_se_align_shift[lane] > 6'd33)
        sticky_mask[lane] = '1;
      else
        sticky_mask[lane] = ~(32'hffff_ffff << (fx1_se_align_shift[lane] - 6'd2));

      // Extend the operands to 64 bits so that one 64x64 multiplier
      // (keeping the low 64 bits) covers both the signed and the unsigned
      // product.
      mul_a[lane] = {is_mulh_i ? {32{fx1_multiplicand[lane][31]}} : 32'h0,
                     fx1_multiplicand[lane]};
      mul_b[lane] = {is_mulh_i ? {32{fx1_multiplier[lane][31]}} : 32'h0,
                     fx1_multiplier[lane]};
    end
  end

  always_comb begin
    instruction_valid_d = fx1_instruction_valid
                          && !(wb_rollback_en && (wb_rollback_thread_idx == fx1_thread_idx));
    instruction_d       = fx1_instruction;
    mask_value_d        = fx1_mask_value;
    thread_idx_d        = fx1_thread_idx;
    subcycle_d          = fx1_subcycle;
    for (int lane = 0; lane < NUM_VECTOR_LANES; lane++) begin
      result_inf_d[lane]          = fx1_result_inf[lane];
      result_nan_d[lane]          = fx1_result_nan[lane];
      equal_d[lane]               = fx1_equal[lane];
      logical_subtract_d[lane]    = fx1_logical_subtract[lane];
      add_result_sign_d[lane]     = fx1_add_result_sign[lane];
      mul_underflow_d[lane]       = fx1_mul_underflow[lane];
      mul_sign_d[lane]            = fx1_mul_sign[lane];
      ftoi_lshift_d[lane]         = fx1_ftoi_lshift[lane];
      add_exponent_d[lane]        = fx1_add_exponent[lane];
      mul_exponent_d[lane]        = fx1_mul_exponent[lane];
      significand_le_d[lane]      = fx1_significand_le[lane];
      significand_se_d[lane]      = align_ext[lane][33:2];
      guard_d[lane]               = align_ext[lane][1];
      round_d[lane]               = align_ext[lane][0];
      sticky_d[lane]              = |(fx1_significand_se[lane] & sticky_mask[lane]);
      significand_product_d[lane] = mul_a[lane] * mul_b[lane];
    end
  end

  // Datapath registers load every cycle. Consumers qualify them with
  // fx2_instruction_valid.
  always_ff @(posedge clk) begin
    if (reset) begin
      instruction_valid_q <= 1'b0;
      instruction_q       <= '0;
      mask_value_q        <= '0;
      thread_idx_q        <= '0;
      subcycle_q          <= '0;
      for (int lane = 0; lane < NUM_VECTOR_LANES; lane++) begin
        result_inf_q[lane]          <= 1'b0;
        result_nan_q[lane]          <= 1'b0;
        equal_q[lane]               <= 1'b0;
        logical_subtract_q[lane]    <= 1'b0;
        add_result_sign_q[lane]     <= 1'b0;
        mul_underflow_q[lane]       <= 1'b0;
        mul_sign_q[lane]            <= 1'b0;
        ftoi_lshift_q[lane]         <= '0;
        add_exponent_q[lane]        <= '0;
        mul_exponent_q[lane]        <= '0;
        significand_le_q[lane]      <= '0;
        significand_se_q[lane]      <= '0;
        guard_q[lane]               <= 1'b0;
        round_q[lane]               <= 1'b0;
        sticky_q[lane]              <= 1'b0;
        significand_product_q[lane] <= '0;
      end
    end else begin
      instruction_valid_q <= instruction_valid_d;
      instruction_q       <= instruction_d;
      mask_value_q        <= mask_value_d;
      thread_idx_q        <= thread_idx_d;
      subcycle_q          <= subcycle_d;
      for (int lane = 0; lane < NUM_VECTOR_LANES; lane++) begin
        result_inf_q[lane]          <= result_inf_d[lane];
        result_nan_q[lane]          <= result_nan_d[lane];
        equal_q[lane]               <= equal_d[lane];
        logical_subtract_q[lane]    <= logical_subtract_d[lane];
        add_result_sign_q[lane]     <= add_result_sign_d[lane];
        mul_underflow_q[lane]       <= mul_underflow_d[lane];
        mul_sign_q[lane]            <= mul_sign_d[lane];
        ftoi_lshift_q[lane]         <= ftoi_lshift_d[lane];
        add_exponent_q[lane]        <= add_exponent_d[lane];
        mul_exponent_q[lane]        <= mul_exponent_d[lane];
        significand_le_q[lane]      <= significand_le_d[lane];
        significand_se_q[lane]      <= significand_se_d[lane];
        guard_q[lane]               <= guard_d[lane];
        round_q[lane]               <= round_d[lane];
        sticky_q[lane]              <= sticky_d[lane];
        significand_product_q[lane] <= significand_product_d[lane];
      end
    end
  end

  assign fx2_instruction_valid = instruction_valid_q;
  assign fx2_instruction       = instruction_q;
  assign fx2_mask_value        = mask_value_q;
  assign fx2_thread_idx        = thread_idx_q;
  assign fx2_subcycle          = subcycle_q;

  always_comb begin
    for (int lane = 0; lane < NUM_VECTOR_LANES; lane++) begin
      fx2_result_inf[lane]          = result_inf_q[lane];
      fx2_result_nan[lane]          = result_nan_q[lane];
      fx2_equal[lane]               = equal_q[lane];
      fx2_logical_subtract[lane]    = logical_subtract_q[lane];
      fx2_add_result_sign[lane]     = add_result_sign_q[lane];
      fx2_mul_underflow[lane]       = mul_underflow_q[lane];
      fx2_mul_sign[lane]            = mul_sign_q[lane];
      fx2_ftoi_lshift[lane]         = ftoi_lshift_q[lane];
      fx2_add_exponent[lane]        = add_exponent_q[lane];
      fx2_mul_exponent[lane]        = mul_exponent_q[lane];
      fx2_significand_le[lane]      = significand_le_q[lane];
      fx2_significand_se[lane]      = significand_se_q[lane];
      fx2_guard[lane]               = guard_q[lane];
      fx2_round[lane]               = round_q[lane];
      fx2_sticky[lane]              = sticky_q[lane];
      fx2_significand_product[lane] = significand_product_q[lane];
    end
  end

endmodule
